ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined datapath's F/D register.
- Replaces the combinational instruction memory read with a variable-latency, in-order request/response instruction memory port.
- Buffers fetched instructions with their PC in a small FIFO and presents InstrF, PCF and PCPlus4F with a valid flag to the decode register.
- Honours StallF from the hazard unit and the PCSrcE/PCTargetE redirect from Execute.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- MAX_OUT, 2, maximum in-flight memory requests, including ones to be discarded.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  1 = hold the head entry; do not pop.
- PCSrcE  in  1  redirect request from Execute.
- PCTargetE  in  32  redirect target address.
- imem_req  out  1  request valid.
- imem_addr  out  32  request address (word aligned).
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response valid; responses return in request order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- ValidF  out  1  head entry valid.
- InstrF  out  32  head instruction, or 32'h00000013 (NOP) when empty.
- PCF  out  32  head PC, or 0 when empty.
- PCPlus4F  out  32  PCF+4, or 0 when empty.

Behaviour:
- Reset (asynchronous): fetch_pc=RESET_PC, count=0, inflight=0, discard=0, FIFO pointers=0.
  - Outputs while reset is asserted: ValidF=0, InstrF=NOP, PCF=0, PCPlus4F=0, imem_req=0.
  - Reset asserted mid-operation drops all entries and in-flight state. Responses arriving after reset releases, for requests issued before reset, are outside the contract.
- Request issue:
  - imem_req = !PCSrcE && inflight<MAX_OUT && (count + inflight − discard) < DEPTH.
  - imem_addr = fetch_pc.
  - On a fire (imem_req && imem_ready): fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
- Response handling (imem_rsp_valid): inflight −= 1.
  - If discard>0, decrement discard and drop the data.
  - Otherwise push {data, PC}. The PC comes from an internal rsp_pc counter that advances by 4 per accepted (non-discarded) response.
  - The credit rule guarantees a push never meets a full FIFO. A push into a full FIFO is an assertion failure.
- Pop: when ValidF && !StallF, the head is consumed at the clock edge.
  - Same-cycle pop and push on the same FIFO are both performed; count is unchanged.
- Outputs: ValidF=(count>0), combinational from the head entry. An entry is visible one cycle after its response. Minimum fetch latency, request fire to ValidF, is memory latency + 1.
- Redirect (PCSrcE=1), highest priority:
  - FIFO cleared: count=0, pointers reset.
  - fetch_pc=PCTargetE, rsp_pc=PCTargetE.
  - No request is issued this cycle.
  - discard_next = inflight_next, i.e. all requests outstanding after this cycle's response is processed.
  - A response arriving in the redirect cycle is dropped regardless of discard.
  - Any pop in the same cycle is void.
  - PCTargetE[1:0] are ignored (forced to 0).
- StallF with an empty FIFO has no effect. Fetching continues while stalled until the credit limit is reached.
- Counter widths: count holds 0..DEPTH; inflight and discard hold 0..MAX_OUT.

Test Plan:
- Zero-wait memory (imem_ready=1, 1-cycle response), StallF=0 after reset → ValidF rises at cycle 2. PCF sequence 0,4,8,12; InstrF matches memory words; sustained 1 instruction/cycle.
- StallF held high for 10 cycles with DEPTH=4, MAX_OUT=2 → count saturates at 4. imem_req=0 once count+live inflight=4; head stays PCF=0. After release, PCF 0,4,8,… with no gaps or duplicates.
- Memory latency 3 cycles, PCSrcE=1 with PCTargetE=32'h100 while 2 requests are in flight and the FIFO holds 2 entries → ValidF=0 next cycle; the 2 late responses are dropped. First valid entry has PCF=32'h100, PCPlus4F=32'h104.
- Redirect in the same cycle as imem_rsp_valid and a pop → response dropped; count=0; next request address=PCTargetE.
- imem_ready toggling randomly, 1–4 cycle latency, 1000 instructions → PCF strictly +4 between redirects; no lost or duplicated instruction; inflight never exceeds 2.
- Assert rst asynchronously mid-stream with 3 entries buffered → outputs go to reset values immediately (ValidF=0, InstrF=32'h00000013). After release, first request address=RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: issues in-order requests to a variable-latency
// instruction memory, buffers {instr, pc} pairs in a small FIFO and presents
// the head entry to the F/D register. Execute redirects flush the FIFO and
// mark every still-outstanding request for discard.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ValidF,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUT + 1);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]     fetchPc_q, fetchPc_d;
  logic [31:0]     rspPc_q, rspPc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [OutW-1:0] inflight_q, inflight_d;
  logic [OutW-1:0] discard_q, discard_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;

  logic [31:0] instrMem [DEPTH];
  logic [31:0] pcMem    [DEPTH];

  logic        fire;
  logic        push;
  logic        pop;
  logic [31:0] target;
  int          liveSlots;
  logic        unusedTargetLsb;

  assign target          = {PCTargetE[31:2], 2'b00};
  assign unusedTargetLsb = ^PCTargetE[1:0];

  // Request credit: FIFO slots already claimed by entries plus live (non-discarded) requests.
  always_comb begin
    liveSlots = int'(count_q) + int'(inflight_q) - int'(discard_q);
    imem_req  = !rst && !PCSrcE && (inflight_q < OutW'(MAX_OUT)) && (liveSlots < int'(DEPTH));
    imem_addr = fetchPc_q;
  end

  assign fire = imem_req && imem_ready;
  // A response during a redirect is dropped regardless of the discard count.
  assign push = imem_rsp_valid && !PCSrcE && (discard_q == '0);
  assign pop  = ValidF && !StallF && !PCSrcE;

  // Next-state for fetch/response PCs, occupancy, credit and discard tracking.
  always_comb begin
    fetchPc_d  = fetchPc_q;
    rspPc_d    = rspPc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    if (PCSrcE) begin
      fetchPc_d  = target;
      rspPc_d    = target;
      count_d    = '0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      inflight_d = inflight_q - OutW'(imem_rsp_valid);
      // Everything still outstanding belongs to the old path.
      discard_d  = inflight_d;
    end else begin
      if (fire) begin
        fetchPc_d = fetchPc_q + 32'd4;
      end
      inflight_d = inflight_q + OutW'(fire) - OutW'(imem_rsp_valid);
      if (imem_rsp_valid && (discard_q != '0)) begin
        discard_d = discard_q - OutW'(1);
      end
      if (push) begin
        wrPtr_d = wrPtr_q + PtrW'(1);
        rspPc_d = rspPc_q + 32'd4;
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q  <= RESET_PC;
      rspPc_q    <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      fetchPc_q  <= fetchPc_d;
      rspPc_q    <= rspPc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      instrMem[wrPtr_q] <= imem_rsp_data;
      pcMem[wrPtr_q]    <= rspPc_q;
    end
  end

  // The credit rule must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == CntW'(DEPTH))))
        else $error("ifetch_queue: push into full FIFO");
    end
  end

  // Head-of-queue outputs, forced to a NOP bubble when empty.
  always_comb begin
    ValidF   = (count_q != '0);
    InstrF   = Nop;
    PCF      = '0;
    PCPlus4F = '0;
    if (ValidF) begin
      InstrF   = instrMem[rdPtr_q];
      PCF      = pcMem[rdPtr_q];
      PCPlus4F = pcMem[rdPtr_q] + 32'd4;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with an in-order variable-latency memory model.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready     = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  int vectors     = 0;
  int miscompares = 0;

  // Memory model state
  int          memLat    = 1;  // 0 selects a random 1..4 latency per request
  bit          randReady = 1'b0;
  logic        fireS;
  logic [31:0] addrS;
  int          mcyc      = 0;
  int          lastDue   = 0;
  int          maxQ      = 0;
  logic [31:0] addrQ[$];
  int          dueQ[$];

  ifetch_queue #(
    .DEPTH   (4),
    .MAX_OUT (2),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .StallF        (StallF),
    .PCSrcE        (PCSrcE),
    .PCTargetE     (PCTargetE),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .ValidF        (ValidF),
    .InstrF        (InstrF),
    .PCF           (PCF),
    .PCPlus4F      (PCPlus4F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a << 5) ^ 32'h0000_0033;
  endfunction

  // Memory: sample the handshake before the edge, update responses 1 after it.
  always begin
    int lat;
    int d;
    @(negedge clk);
    fireS = imem_req && imem_ready;
    addrS = imem_addr;
    @(posedge clk);
    #1;
    mcyc++;
    if (rst) begin
      addrQ.delete();
      dueQ.delete();
      lastDue        = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (imem_rsp_valid) begin
        void'(addrQ.pop_front());
        void'(dueQ.pop_front());
      end
      if (fireS) begin
        lat = (memLat == 0) ? int'($urandom_range(1, 4)) : memLat;
        d   = mcyc + lat;
        if (d <= lastDue) d = lastDue + 1;
        lastDue = d;
        addrQ.push_back(addrS);
        dueQ.push_back(d);
      end
      if (addrQ.size() > maxQ) maxQ = addrQ.size();
      imem_rsp_valid = (addrQ.size() > 0) && (dueQ[0] <= mcyc + 1);
      imem_rsp_data  = imem_rsp_valid ? memWord(addrQ[0]) : 32'h0;
    end
    imem_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Leaves the bench at the negedge of cycle 0 after reset release.
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] expPc;
    int          popped;
    int          w;

    rst       = 1'b1;
    StallF    = 1'b0;
    PCSrcE    = 1'b0;
    PCTargetE = 32'h0;

    // Reset values
    @(negedge clk);
    check("rstValid", 32'(ValidF), 32'd0);
    check("rstInstr", InstrF, 32'h0000_0013);
    check("rstPc", PCF, 32'h0);
    check("rstPc4", PCPlus4F, 32'h0);
    check("rstReq", 32'(imem_req), 32'd0);

    // Zero-wait memory, sustained one instruction per cycle
    doReset();
    check("t1Req", 32'(imem_req), 32'd1);
    check("t1Addr", imem_addr, 32'h0);
    check("t1Valid0", 32'(ValidF), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t1Valid1", 32'(ValidF), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      check("t1Valid", 32'(ValidF), 32'd1);
      check("t1Pc", PCF, 32'(4 * k));
      check("t1Pc4", PCPlus4F, 32'(4 * k + 4));
      check("t1Instr", InstrF, memWord(32'(4 * k)));
    end

    // Stall saturation, then gapless drain
    StallF = 1'b1;
    doReset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2Valid", 32'(ValidF), 32'd1);
    check("t2HeadPc", PCF, 32'h0);
    check("t2ReqOff", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 StallF = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("t2Valid", 32'(ValidF), 32'd1);
      check("t2Pc", PCF, 32'(4 * j));
      @(posedge clk);
    end

    // Latency 3, redirect with 2 entries buffered and 2 requests in flight
    StallF = 1'b1;
    memLat = 3;
    doReset();
    repeat (6) @(posedge clk);
    #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0100;
    @(negedge clk);
    check("t3ReqRedir", 32'(imem_req), 32'd0);
    check("t3PreValid", 32'(ValidF), 32'd1);
    check("t3PrePc", PCF, 32'h0);
    @(posedge clk);
    #1 PCSrcE = 1'b0;
    @(negedge clk);
    check("t3Flushed", 32'(ValidF), 32'd0);
    check("t3NopInstr", InstrF, 32'h0000_0013);
    check("t3PcZero", PCF, 32'h0);
    check("t3Pc4Zero", PCPlus4F, 32'h0);
    check("t3ReqHeld", 32'(imem_req), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t3Req", 32'(imem_req), 32'd1);
    check("t3Addr", imem_addr, 32'h0000_0100);
    w = 0;
    while (!ValidF && w < 20) begin
      @(posedge clk); @(negedge clk);
      w++;
    end
    check("t3Valid", 32'(ValidF), 32'd1);
    check("t3Pc", PCF, 32'h0000_0100);
    check("t3Pc4", PCPlus4F, 32'h0000_0104);
    check("t3Instr", InstrF, memWord(32'h0000_0100));

    // Redirect colliding with a response and a pop; low target bits ignored
    StallF = 1'b0;
    memLat = 1;
    doReset();
    repeat (4) @(posedge clk);
    #1;
    PCSrcE    = 1'b1;
    PCTargetE = 32'h0000_0203;
    @(negedge clk);
    check("t4PreValid", 32'(ValidF), 32'd1);
    check("t4PrePc", PCF, 32'h8);
    check("t4ReqRedir", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 PCSrcE = 1'b0;
    @(negedge clk);
    check("t4Flushed", 32'(ValidF), 32'd0);
    check("t4Req", 32'(imem_req), 32'd1);
    check("t4Addr", imem_addr, 32'h0000_0200);
    @(posedge clk); @(negedge clk);
    check("t4Empty", 32'(ValidF), 32'd0);
    @(posedge clk); @(negedge clk);
    check("t4Valid", 32'(ValidF), 32'd1);
    check("t4Pc", PCF, 32'h0000_0200);
    check("t4Instr", InstrF, memWord(32'h0000_0200));

    // Asynchronous reset with 3 entries buffered
    StallF = 1'b1;
    doReset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t6PreValid", 32'(ValidF), 32'd1);
    check("t6PrePc", PCF, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("t6Valid", 32'(ValidF), 32'd0);
    check("t6Instr", InstrF, 32'h0000_0013);
    check("t6Pc", PCF, 32'h0);
    check("t6Pc4", PCPlus4F, 32'h0);
    check("t6Req", 32'(imem_req), 32'd0);
    StallF = 1'b0;
    doReset();
    check("t6ReqAfter", 32'(imem_req), 32'd1);
    check("t6AddrAfter", imem_addr, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("t6FirstValid", 32'(ValidF), 32'd1);
    check("t6FirstPc", PCF, 32'h0);

    // Random ready, random 1..4 latency, random stalls and redirects
    memLat    = 0;
    randReady = 1'b1;
    doReset();
    maxQ   = 0;
    expPc  = 32'h0;
    popped = 0;
    for (int c = 0; c < 20000 && popped < 1000; c++) begin
      if (PCSrcE) begin
        expPc = PCTargetE & 32'hFFFF_FFFC;
      end else if (ValidF && !StallF) begin
        check("t5Pc", PCF, expPc);
        check("t5Instr", InstrF, memWord(expPc));
        expPc = expPc + 32'd4;
        popped++;
      end
      @(posedge clk);
      #1;
      StallF    = ($urandom_range(0, 3) == 0);
      PCSrcE    = (c == 0) || ($urandom_range(0, 79) == 0);
      PCTargetE = (c == 0) ? 32'hFFFF_FFF6 : $urandom;
      @(negedge clk);
    end
    PCSrcE = 1'b0;
    StallF = 1'b0;
    check("t5PopCount", 32'(popped), 32'd1000);
    check("t5MaxInflight", 32'(maxQ <= 2), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
